// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweep engine.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } tt_state_t;

   // Number of input vectors (truth-table rows) for an n-input function.
   function automatic int tt_nvec(input int n);
      return 1 << n;
   endfunction

   // Width of the settle down-counter for a given hold time.
   function automatic int tt_cnt_w(input int settle_cyc);
      return $clog2(settle_cyc + 1);
   endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that flags when a vector has been held long enough.
module tt_settle_timer
   import tt_pkg::*;
#(
   parameter int SETTLE_CYC = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic expire
);

   localparam int CW = tt_cnt_w(SETTLE_CYC);
   localparam logic [CW-1:0] LOAD_VAL = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt;

   // Count down from the load value and rest at zero until reloaded.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_ONE;
      end
   end

   // Loading SETTLE_CYC-1 makes expire true in the SETTLE_CYC-th settle cycle.
   assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector of an N-input function, samples its output
// after a settle time and assembles the truth table as a minterm mask.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int N          = 3,
   parameter int SETTLE_CYC = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   f,
   input  logic [tt_nvec(N)-1:0]  expected,
   output logic [N-1:0]           vec,
   output logic                   busy,
   output logic                   done,
   output logic [tt_nvec(N)-1:0]  mask,
   output logic [N:0]             ones,
   output logic                   match
);

   localparam int NV = tt_nvec(N);
   localparam logic [N-1:0] VEC_ONE  = N'(1);
   localparam logic [N-1:0] VEC_LAST = '1;
   localparam logic [N:0]   ONES_ONE = (N + 1)'(1);

   tt_state_t       state;
   tt_state_t       state_next;
   logic            load;
   logic            expire;
   logic            last;
   logic [NV-1:0]   mask_cap;

   tt_settle_timer #(
      .SETTLE_CYC (SETTLE_CYC)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .expire (expire)
   );

   assign last = (vec == VEC_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode, status outputs and settle-timer reload.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SETTLE;
               load       = 1'b1;
            end
         end
         SETTLE: begin
            busy = 1'b1;
            if (expire) begin
               state_next = SAMPLE;
            end
         end
         SAMPLE: begin
            busy = 1'b1;
            if (last) begin
               state_next = DONE;
            end else begin
               state_next = SETTLE;
               load       = 1'b1;
            end
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_next = SETTLE;
               load       = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Mask as it will look after the current sample; feeds the final compare.
   always_comb begin
      mask_cap      = mask;
      mask_cap[vec] = f;
   end

   // Vector counter, mask/ones accumulation and final match register.
   always_ff @(posedge clk) begin
      if (reset) begin
         vec   <= '0;
         mask  <= '0;
         ones  <= '0;
         match <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  vec   <= '0;
                  mask  <= '0;
                  ones  <= '0;
                  match <= 1'b0;
               end
            end
            SAMPLE: begin
               mask <= mask_cap;
               if (f) begin
                  ones <= ones + ONES_ONE;
               end
               if (!last) begin
                  vec <= vec + VEC_ONE;
               end else begin
                  match <= (mask_cap == expected);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: table vectors, random
// truth tables against a behavioural model, and reset/restart sequences.
module tb_truth_table_sweeper;

   logic       clk = 1'b0;
   logic       r1, s1, r3, s3;
   logic [7:0] ftab, expv;
   logic       f1, f3;
   logic       d1 = 1'b0, d2 = 1'b0, d3 = 1'b0;
   logic [2:0] vec1, vec3;
   logic       busy1, busy3, done1, done3, match1, match3;
   logic [7:0] mask1, mask3;
   logic [3:0] ones1, ones3;

   int         checks = 0;
   int         errors = 0;
   int         sel    = 0;

   logic [2:0] cur_vec;
   logic       cur_busy, cur_done, cur_match;
   logic [7:0] cur_mask;
   logic [3:0] cur_ones;

   always #5 clk = ~clk;

   truth_table_sweeper #(.N(3), .SETTLE_CYC(1)) dut1 (
      .clk(clk), .reset(r1), .start(s1), .f(f1), .expected(expv),
      .vec(vec1), .busy(busy1), .done(done1), .mask(mask1),
      .ones(ones1), .match(match1)
   );

   truth_table_sweeper #(.N(3), .SETTLE_CYC(3)) dut3 (
      .clk(clk), .reset(r3), .start(s3), .f(f3), .expected(expv),
      .vec(vec3), .busy(busy3), .done(done3), .mask(mask3),
      .ones(ones3), .match(match3)
   );

   // Function under test: table lookup, combinational for dut1 and
   // three register stages deep for dut3.
   assign f1 = ftab[vec1];
   assign f3 = d3;
   always @(posedge clk) begin
      d1 <= ftab[vec3];
      d2 <= d1;
      d3 <= d2;
   end

   always_comb begin
      if (sel == 1) begin
         cur_vec = vec3; cur_busy = busy3; cur_done = done3;
         cur_match = match3; cur_mask = mask3; cur_ones = ones3;
      end else begin
         cur_vec = vec1; cur_busy = busy1; cur_done = done1;
         cur_match = match1; cur_mask = mask1; cur_ones = ones1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive_start(input logic v);
      if (sel == 1) s3 = v;
      else          s1 = v;
   endtask

   // Reference truth table of ~((~a|~b)&~(a&c)), a = MSB.
   function automatic logic [7:0] ref_tab();
      logic [7:0] t;
      logic [2:0] k;
      logic a, b, c;
      for (int i = 0; i < 8; i++) begin
         k = 3'(i);
         a = k[2]; b = k[1]; c = k[0];
         t[i] = ~((~a | ~b) & ~(a & c));
      end
      return t;
   endfunction

   // One full sweep on the selected instance. Checks the start-edge clear,
   // busy/vec progression against the timing model, and returns results.
   task automatic sweep(input logic [7:0] tab, input logic [7:0] ex,
                        input int pulse_at, input string tag,
                        output logic [7:0] m, output logic [3:0] o,
                        output logic mt, output int cyc);
      int c, bad, s, t, mv;
      s = (sel == 1) ? 3 : 1;
      t = 8 * (s + 1);
      ftab = tab;
      expv = ex;
      @(negedge clk);
      drive_start(1'b1);
      @(posedge clk); #1;
      drive_start(1'b0);
      chk({tag, "_clear"}, {cur_mask, cur_ones, cur_match, cur_done, cur_busy, cur_vec},
          {8'h00, 4'h0, 1'b0, 1'b0, 1'b1, 3'd0});
      c = 0;
      bad = 0;
      while (!cur_done && c < t + 8) begin
         @(posedge clk); #1;
         c++;
         drive_start(c == pulse_at);
         mv = c / (s + 1);
         if (mv > 7) mv = 7;
         if (int'(cur_vec) != mv) bad++;
         if (!cur_done && !cur_busy) bad++;
      end
      drive_start(1'b0);
      chk({tag, "_progress"}, bad, 0);
      chk({tag, "_busy_at_done"}, {31'd0, cur_busy}, 0);
      m   = cur_mask;
      o   = cur_ones;
      mt  = cur_match;
      cyc = c;
   endtask

   typedef struct {
      logic [7:0] tab;
      logic [7:0] ex;
      logic [7:0] mask;
      logic [3:0] ones;
      logic       match;
   } tv_t;

   tv_t        tv[7];
   logic [7:0] m, rtab, rex;
   logic [3:0] o;
   logic       mt;
   int         cyc;

   initial begin
      r1 = 1'b1; r3 = 1'b1; s1 = 1'b0; s3 = 1'b0;
      ftab = 8'h00; expv = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_dut1", {vec1, busy1, done1, mask1, ones1, match1}, 0);
      chk("reset_dut3", {vec3, busy3, done3, mask3, ones3, match3}, 0);
      @(negedge clk);
      r1 = 1'b0; r3 = 1'b0;

      tv[0] = '{ref_tab(), 8'hE0, 8'hE0, 4'd3, 1'b1};
      tv[1] = '{ref_tab(), 8'hE1, 8'hE0, 4'd3, 1'b0};
      tv[2] = '{8'hFF,     8'hFF, 8'hFF, 4'd8, 1'b1};
      tv[3] = '{8'h00,     8'h00, 8'h00, 4'd0, 1'b1};
      tv[4] = '{8'h96,     8'h96, 8'h96, 4'd4, 1'b1};
      tv[5] = '{8'h01,     8'h80, 8'h01, 4'd1, 1'b0};
      tv[6] = '{8'h80,     8'h80, 8'h80, 4'd1, 1'b1};

      sel = 0;
      for (int i = 0; i < 7; i++) begin
         sweep(tv[i].tab, tv[i].ex, -1, $sformatf("tv%0d", i), m, o, mt, cyc);
         chk($sformatf("tv%0d_cycles", i), cyc, 16);
         chk($sformatf("tv%0d_mask", i), m, tv[i].mask);
         chk($sformatf("tv%0d_ones", i), o, tv[i].ones);
         chk($sformatf("tv%0d_match", i), mt, tv[i].match);
      end

      // Start mid-sweep is ignored; then restart from DONE with f = 1.
      sweep(ref_tab(), 8'hE0, 5, "ign", m, o, mt, cyc);
      chk("ign_cycles", cyc, 16);
      chk("ign_mask", m, 8'hE0);
      sweep(8'hFF, 8'hE0, -1, "restart", m, o, mt, cyc);
      chk("restart_mask", m, 8'hFF);
      chk("restart_ones", o, 8);
      chk("restart_match", mt, 0);

      // Settle latency with a three-register-deep a&b&c.
      sel = 1;
      sweep(8'h80, 8'h80, -1, "lat", m, o, mt, cyc);
      chk("lat_cycles", cyc, 32);
      chk("lat_mask", m, 8'h80);
      chk("lat_ones", o, 1);
      chk("lat_match", mt, 1);

      // Random truth tables against the behavioural model.
      for (int i = 0; i < 16; i++) begin
         sel  = (i % 4 == 3) ? 1 : 0;
         rtab = 8'($urandom);
         rex  = ($urandom_range(0, 1) == 1) ? rtab : 8'($urandom);
         sweep(rtab, rex, -1, $sformatf("rnd%0d", i), m, o, mt, cyc);
         chk($sformatf("rnd%0d_cycles", i), cyc, (sel == 1) ? 32 : 16);
         chk($sformatf("rnd%0d_mask", i), m, rtab);
         chk($sformatf("rnd%0d_ones", i), o, $countones(rtab));
         chk($sformatf("rnd%0d_match", i), mt, (rtab == rex) ? 1 : 0);
      end

      // Reset at the 7th cycle of a sweep aborts it for good.
      sel = 0;
      ftab = 8'hFF;
      @(negedge clk);
      s1 = 1'b1;
      @(posedge clk); #1;
      s1 = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("pre_reset_mask_nonzero", {31'd0, (mask1 != 8'h00)}, 1);
      r1 = 1'b1;
      @(posedge clk); #1;
      r1 = 1'b0;
      chk("midreset_state", {vec1, mask1, ones1, busy1, done1, match1}, 0);
      repeat (5) @(posedge clk);
      #1;
      chk("midreset_stays_idle", {vec1, busy1, done1}, 0);

      // Finish a sweep to reach DONE, then reset and start together.
      sweep(8'h0F, 8'h0F, -1, "pre_sim", m, o, mt, cyc);
      chk("pre_sim_done", {31'd0, done1}, 1);
      @(negedge clk);
      r1 = 1'b1; s1 = 1'b1;
      @(posedge clk); #1;
      r1 = 1'b0; s1 = 1'b0;
      chk("sim_rst_start", {busy1, done1, vec1, mask1}, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("sim_rst_start_idle", {busy1, done1}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
